pll_phase_stepper: RTL
======================

PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 SETUP_CYC, default 2: cycles PHASESEL/PHASEDIR are held stable before each step pulse, legal range 1..15.
REQ-002 PULSE_CYC, default 4: PHASESTEP low-pulse width in cycles, legal range 1..15.
REQ-003 GAP_CYC, default 8: PHASESTEP high cycles between consecutive pulses, legal range 1..255.
REQ-004 LOCK_TMO, default 4096: max cycles to wait for pll_locked after the last pulse, legal range 1..65535.
REQ-005 clock  in  1  system clock, the only clock; all logic rising-edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  phase-step request.
REQ-008 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-009 req_sel  in  2  output select: 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3.
REQ-010 req_dir  in  1  direction: 1=lag, 0=lead; drives PLL PHASEDIR.
REQ-011 req_steps  in  8  number of step pulses, 0 legal.
REQ-012 pll_locked  in  1  PLL LOCK, asynchronous to clock.
REQ-013 phasesel  out  2  to PLL PHASESEL1:0.
REQ-014 phasedir  out  1  to PLL PHASEDIR.
REQ-015 phasestep  out  1  to PLL PHASESTEP, idle high, active-low pulse.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse on successful completion.
REQ-018 error  out  1  one-cycle pulse on lock timeout or lock loss.

Function
REQ-019 pll_locked shall pass through a 2-flop synchronizer; "locked" below means the synchronized value.
REQ-020 FSM states: IDLE, SETUP, PULSE, GAP, LOCKWAIT.
REQ-021 req_ready = 1 only in IDLE with locked = 1.
REQ-022 On acceptance: latch req_sel, req_dir, req_steps; drive phasesel and phasedir from the latched values on the next cycle; go to SETUP, or to LOCKWAIT if req_steps = 0.
REQ-023 phasesel and phasedir shall change only on acceptance and hold their latched values through the whole operation and afterwards.
REQ-024 SETUP lasts SETUP_CYC cycles -> PULSE.
REQ-025 PULSE: phasestep = 0 for exactly PULSE_CYC cycles; remaining-step count decrements at pulse end; -> GAP.
REQ-026 GAP: phasestep = 1 for GAP_CYC cycles; then -> PULSE if remaining > 0, else -> LOCKWAIT.
REQ-027 phasestep shall be registered, glitch-free, and low only in PULSE.
REQ-028 LOCKWAIT: on the first cycle with locked = 1, pulse done and return to IDLE.
REQ-029 LOCKWAIT: if LOCK_TMO cycles elapse without locked = 1, pulse error and return to IDLE.
REQ-030 locked falling in SETUP/PULSE/GAP is tolerated, and stepping continues.
REQ-031 done and error shall never assert in the same cycle.
REQ-032 Exactly req_steps low pulses are issued per accepted request, with no count wrap: 255 means 255 pulses.
REQ-033 req_valid outside IDLE shall be ignored (not queued).
REQ-034 The cycle count from acceptance to the last pulse end = 1 + SETUP_CYC + N*PULSE_CYC + (N-1)*GAP_CYC, for N > 0.

Reset
REQ-035 During resetn = 0: state IDLE, phasestep = 1, phasesel = 0, phasedir = 0, busy/done/error = 0, req_ready = 0, counters and synchronizer cleared.
REQ-036 Reset assertion mid-operation aborts immediately, with phasestep forced high asynchronously; no done/error pulse is issued.
REQ-037 After resetn deasserts, req_ready rises no earlier than 2 cycles after locked is seen high.

Verification
REQ-038 Defaults, locked = 1, request sel=1 dir=1 steps=3 -> 3 low pulses of 4 cycles, 8-cycle gaps, phasesel = 1 and phasedir = 1 throughout, then done 1 cycle after locked (already high).
REQ-039 steps=0 with locked = 1 -> no phasestep activity; done within 2 cycles of LOCKWAIT entry.
REQ-040 steps=1, locked forced 0 at the pulse start and held low -> busy stays high; error exactly LOCK_TMO cycles after LOCKWAIT entry; then IDLE with req_ready = 0 until relock.
REQ-041 steps=255 -> 255 pulses counted, done asserted, no extra pulse.
REQ-042 resetn pulled low during PULSE -> phasestep high with no clock edge; outputs at reset values; after release and lock, a new request completes normally.
REQ-043 req_valid toggled and req_sel changed while busy -> phasesel unchanged and no second operation starts.

Source files
------------

// File: rtl/pll_phase_stepper_if.sv
// Request handshake bundle for the PLL phase stepper: a requester (master) asks for
// a number of phase steps on one PLL output in one direction.
interface pll_phase_stepper_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;

  modport master (
    output req_valid,
    output req_sel,
    output req_dir,
    output req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    input  req_dir,
    input  req_steps,
    output req_ready
  );
endinterface

// File: rtl/pll_phase_stepper.sv
// Drives the PLL dynamic phase-shift port: latches a request, issues N active-low
// PHASESTEP pulses with setup/gap spacing, then waits (bounded) for the PLL to relock.
module pll_phase_stepper #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 8,
  parameter int unsigned LOCK_TMO  = 4096
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  pll_phase_stepper_if.slave req_if,
  input  logic               i_pll_locked,
  output logic [1:0]         o_phasesel,
  output logic               o_phasedir,
  output logic               o_phasestep,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSetup    = 3'd1;
  localparam logic [2:0] StPulse    = 3'd2;
  localparam logic [2:0] StGap      = 3'd3;
  localparam logic [2:0] StLockWait = 3'd4;

  localparam logic [15:0] SetupLd = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PulseLd = 16'(PULSE_CYC - 1);
  localparam logic [15:0] GapLd   = 16'(GAP_CYC - 1);
  localparam logic [15:0] TmoLd   = 16'(LOCK_TMO - 1);

  logic [2:0]  r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [7:0]  r_rem, w_rem_d;
  logic        r_lock_meta, r_lock_sync;
  logic [1:0]  r_phasesel;
  logic        r_phasedir;
  logic        r_phasestep;
  logic        r_done, r_error;
  logic        w_ready, w_accept, w_done_d, w_error_d;

  assign w_ready          = (r_state == StIdle) && r_lock_sync;
  assign w_accept         = req_if.req_valid && w_ready;
  assign req_if.req_ready = w_ready;

  assign o_phasesel  = r_phasesel;
  assign o_phasedir  = r_phasedir;
  assign o_phasestep = r_phasestep;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_error     = r_error;

  // pll_locked is asynchronous to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // r_cnt is loaded with (duration - 1) on state entry and counts down to zero.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_rem_d   = r_rem;
    w_done_d  = 1'b0;
    w_error_d = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_rem_d = req_if.req_steps;
          if (req_if.req_steps == 8'd0) begin
            w_state_d = StLockWait;
            w_cnt_d   = TmoLd;
          end else begin
            w_state_d = StSetup;
            w_cnt_d   = SetupLd;
          end
        end
      end
      StSetup: begin
        if (r_cnt == 16'd0) begin
          w_state_d = StPulse;
          w_cnt_d   = PulseLd;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StPulse: begin
        if (r_cnt == 16'd0) begin
          w_state_d = StGap;
          w_cnt_d   = GapLd;
          w_rem_d   = r_rem - 8'd1;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StGap: begin
        if (r_cnt == 16'd0) begin
          if (r_rem != 8'd0) begin
            w_state_d = StPulse;
            w_cnt_d   = PulseLd;
          end else begin
            w_state_d = StLockWait;
            w_cnt_d   = TmoLd;
          end
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StLockWait: begin
        if (r_lock_sync) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end else if (r_cnt == 16'd0) begin
          w_state_d = StIdle;
          w_error_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 16'd0;
      r_rem       <= 8'd0;
      r_phasesel  <= 2'd0;
      r_phasedir  <= 1'b0;
      r_phasestep <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_rem       <= w_rem_d;
      // Registered from next state so PHASESTEP is low exactly while in PULSE.
      r_phasestep <= (w_state_d != StPulse);
      r_done      <= w_done_d;
      r_error     <= w_error_d;
      if (w_accept) begin
        r_phasesel <= req_if.req_sel;
        r_phasedir <= req_if.req_dir;
      end
    end
  end

endmodule
